// File: rtl/booth_final_cpa.sv
// booth_final_cpa: final carry-propagate adder for the Booth multiplier.
// Resolves the sum/carry pair from the last 3:2 compression stage into the
// binary product over two pipeline stages. Stage 1 adds the low half and
// keeps its carry. Stage 2 adds the high half plus that carry. Both sides
// use valid/ready handshakes, so the tree can be stalled without losing data.
module booth_final_cpa #(
  parameter int SW    = 29,
  parameter int CW    = 27,
  parameter int C_OFS = 5,
  parameter int OW    = 32,
  parameter int LO_W  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [SW-1:0] in_sum,
  input  logic [CW-1:0] in_carry,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_prod
);

  localparam int HI_W = OW - LO_W;

  logic [OW-1:0]   a_op;
  logic [OW-1:0]   b_op;
  logic [LO_W:0]   lo_sum;
  logic [HI_W-1:0] hi_sum;

  logic [LO_W-1:0] lo1;
  logic            cy1;
  logic [HI_W-1:0] ahi1;
  logic [HI_W-1:0] bhi1;
  logic            v1;
  logic            v2;

  logic            en1;
  logic            en2;

  // Align both operands to product weight. The carry vector starts at bit C_OFS.
  always_comb begin
    a_op = OW'(in_sum);
    b_op = OW'(in_carry) << C_OFS;
  end

  // Low-half add, with one extra bit to capture the carry into the high half.
  always_comb begin
    lo_sum = {1'b0, a_op[LO_W-1:0]} + {1'b0, b_op[LO_W-1:0]};
  end

  // High-half add. The carry out of the MSB is dropped, so the product wraps.
  always_comb begin
    hi_sum = ahi1 + bhi1 + {{(HI_W-1){1'b0}}, cy1};
  end

  // Pipeline enables. A stage may load when it is empty or when its content moves on.
  always_comb begin
    en2       = !v2 || out_ready;
    en1       = !v1 || en2;
    in_ready  = en1;
    out_valid = v2;
  end

  // Stage 1 registers. Data loads only with a real pair, so bubbles leave the data untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      lo1  <= '0;
      cy1  <= 1'b0;
      ahi1 <= '0;
      bhi1 <= '0;
    end else if (en1) begin
      v1 <= in_valid;
      if (in_valid) begin
        {cy1, lo1} <= lo_sum;
        ahi1       <= a_op[OW-1:LO_W];
        bhi1       <= b_op[OW-1:LO_W];
      end
    end
  end

  // Stage 2 registers. out_prod holds its value while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2       <= 1'b0;
      out_prod <= '0;
    end else if (en2) begin
      v2 <= v1;
      if (v1) begin
        out_prod <= {hi_sum, lo1};
      end
    end
  end

endmodule
